// File: rtl/instr_fetch_unit.sv
// TRISC fetch stage: owns PC and IR, fetches over a req/ack handshake,
// holds opcode/operand for execute, traps illegal opcodes, supports halt.
module instr_fetch_unit #(
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = 8,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               reset,
    output logic               mem_req,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic               mem_ack,
    input  logic [INSTR_W-1:0] mem_rdata,
    output logic [3:0]         opcode,
    output logic [INSTR_W-5:0] operand,
    output logic               instr_valid,
    input  logic               instr_done,
    input  logic               pc_load,
    input  logic [ADDR_W-1:0]  pc_load_val,
    input  logic               halt,
    output logic [ADDR_W-1:0]  pc,
    output logic               halted,
    output logic               illegal_op,
    output logic [CNT_W-1:0]   retired_cnt
);

    typedef enum logic [1:0] {
        S_FETCH  = 2'd0,
        S_EXEC   = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    // Bit n set means opcode n is defined:
    // 0,1,2,3,4,6,7,8,9,12,15 legal; 5,10,11,13,14 trap.
    localparam logic [15:0] LEGAL_MASK = 16'h93DF;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [INSTR_W-1:0] ir_q, ir_d;
    logic               illegal_q, illegal_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [3:0] rd_op;
    logic       rd_legal;

    // Opcode field of the incoming word, checked before it lands in IR.
    always_comb begin
        rd_op    = mem_rdata[INSTR_W-1 -: 4];
        rd_legal = LEGAL_MASK[rd_op];
    end

    // Next-state logic for the fetch/execute/halt sequence.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        illegal_d = illegal_q;
        cnt_d     = cnt_q;
        unique case (state_q)
            S_FETCH: begin
                if (mem_ack) begin
                    ir_d = mem_rdata;
                    if (rd_legal) begin
                        state_d = S_EXEC;
                    end else begin
                        state_d   = S_HALTED;
                        illegal_d = 1'b1;
                    end
                end
            end
            S_EXEC: begin
                if (instr_done) begin
                    cnt_d = cnt_q + 1'b1;
                    if (halt) begin
                        state_d = S_HALTED;
                    end else if (pc_load) begin
                        pc_d    = pc_load_val;
                        state_d = S_FETCH;
                    end else begin
                        pc_d    = pc_q + 1'b1;
                        state_d = S_FETCH;
                    end
                end
            end
            S_HALTED: begin
                state_d = S_HALTED;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_FETCH;
            pc_q      <= '0;
            ir_q      <= '0;
            illegal_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            illegal_q <= illegal_d;
            cnt_q     <= cnt_d;
        end
    end

    // Outputs decode directly from registered state, so they are glitch-free.
    always_comb begin
        mem_req     = (state_q == S_FETCH) && !reset;
        mem_addr    = pc_q;
        pc          = pc_q;
        opcode      = ir_q[INSTR_W-1 -: 4];
        operand     = ir_q[INSTR_W-5:0];
        instr_valid = (state_q == S_EXEC);
        halted      = (state_q == S_HALTED);
        illegal_op  = illegal_q;
        retired_cnt = cnt_q;
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a fetch-word scoreboard.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_req;
    logic [7:0]  mem_addr;
    logic        mem_ack;
    logic [7:0]  mem_rdata;
    logic [3:0]  opcode;
    logic [3:0]  operand;
    logic        instr_valid;
    logic        instr_done;
    logic        pc_load;
    logic [7:0]  pc_load_val;
    logic        halt;
    logic [7:0]  pc;
    logic        halted;
    logic        illegal_op;
    logic [15:0] retired_cnt;

    logic [7:0] mem [256];
    logic [7:0] sb [$];

    int n_cmp  = 0;
    int n_fail = 0;

    assign mem_rdata = mem[mem_addr];

    always #5 clk = ~clk;

    instr_fetch_unit #(
        .ADDR_W(8),
        .INSTR_W(8),
        .CNT_W(16)
    ) dut (
        .clk(clk),
        .reset(reset),
        .mem_req(mem_req),
        .mem_addr(mem_addr),
        .mem_ack(mem_ack),
        .mem_rdata(mem_rdata),
        .opcode(opcode),
        .operand(operand),
        .instr_valid(instr_valid),
        .instr_done(instr_done),
        .pc_load(pc_load),
        .pc_load_val(pc_load_val),
        .halt(halt),
        .pc(pc),
        .halted(halted),
        .illegal_op(illegal_op),
        .retired_cnt(retired_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] addr);
        sb.push_back(mem[addr]);
    endtask

    task automatic pop_chk(input string tag);
        logic [7:0] e;
        chk({tag, "_valid"}, {31'd0, instr_valid}, 32'd1);
        if (sb.size() == 0) begin
            n_cmp++;
            n_fail++;
            $error("FAIL %s_sb obs=empty exp=entry", tag);
        end else begin
            e = sb.pop_front();
            chk({tag, "_word"}, {24'd0, opcode, operand}, {24'd0, e});
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h00] = 8'h10;
        mem[8'h01] = 8'h23;
        reset       = 1'b1;
        mem_ack     = 1'b0;
        instr_done  = 1'b0;
        pc_load     = 1'b0;
        pc_load_val = 8'h00;
        halt        = 1'b0;
        tick();
        tick();

        chk("rst_req", {31'd0, mem_req}, 32'd0);
        chk("rst_pc", {24'd0, pc}, 32'd0);
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        chk("rst_ill", {31'd0, illegal_op}, 32'd0);
        chk("rst_cnt", {16'd0, retired_cnt}, 32'd0);

        // Back-to-back: ack tied high, done high.
        reset      = 1'b0;
        mem_ack    = 1'b1;
        instr_done = 1'b1;
        #1;
        chk("b2b_req0", {31'd0, mem_req}, 32'd1);
        chk("b2b_addr0", {24'd0, mem_addr}, 32'h00);
        push(8'h00);
        tick();
        pop_chk("b2b_i0");
        chk("b2b_op0", {28'd0, opcode}, 32'h1);
        chk("b2b_req_exec", {31'd0, mem_req}, 32'd0);
        tick();
        chk("b2b_valid_f1", {31'd0, instr_valid}, 32'd0);
        chk("b2b_addr1", {24'd0, mem_addr}, 32'h01);
        push(8'h01);
        tick();
        pop_chk("b2b_i1");
        chk("b2b_op1", {28'd0, opcode}, 32'h2);
        tick();
        chk("b2b_addr2", {24'd0, mem_addr}, 32'h02);
        chk("b2b_cnt", {16'd0, retired_cnt}, 32'd2);

        // Delayed ack.
        mem_ack = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("dly_req", {31'd0, mem_req}, 32'd1);
            chk("dly_addr", {24'd0, mem_addr}, 32'h02);
            chk("dly_valid", {31'd0, instr_valid}, 32'd0);
        end
        mem[8'h02] = 8'h30;
        mem_ack    = 1'b1;
        push(8'h02);
        tick();
        pop_chk("dly_i2");

        // Branch to 0x40.
        mem_ack     = 1'b0;
        pc_load     = 1'b1;
        pc_load_val = 8'h40;
        tick();
        chk("br_addr", {24'd0, mem_addr}, 32'h40);
        chk("br_cnt", {16'd0, retired_cnt}, 32'd3);

        // Jump to 0xFF, then sequential wrap to 0x00.
        mem[8'h40]  = 8'h41;
        mem[8'hFF]  = 8'h67;
        mem_ack     = 1'b1;
        pc_load_val = 8'hFF;
        push(8'h40);
        tick();
        pop_chk("br_i40");
        tick();
        chk("wrap_pcff", {24'd0, pc}, 32'hFF);
        pc_load = 1'b0;
        push(8'hFF);
        tick();
        pop_chk("wrap_iff");
        tick();
        chk("wrap_pc0", {24'd0, pc}, 32'h00);
        chk("wrap_cnt", {16'd0, retired_cnt}, 32'd5);

        // Go to PC=3, then halt with pc_load also asserted.
        push(8'h00);
        tick();
        pop_chk("hp_i0");
        pc_load     = 1'b1;
        pc_load_val = 8'h03;
        tick();
        chk("hp_pc3", {24'd0, pc}, 32'h03);
        mem[8'h03]  = 8'h99;
        pc_load_val = 8'h10;
        halt        = 1'b1;
        push(8'h03);
        tick();
        pop_chk("hp_i3");
        tick();
        chk("hp_halted", {31'd0, halted}, 32'd1);
        chk("hp_pc", {24'd0, pc}, 32'h03);
        chk("hp_cnt", {16'd0, retired_cnt}, 32'd7);
        chk("hp_req", {31'd0, mem_req}, 32'd0);
        chk("hp_valid", {31'd0, instr_valid}, 32'd0);
        tick();
        tick();
        chk("hp_stay", {31'd0, halted}, 32'd1);
        chk("hp_stay_cnt", {16'd0, retired_cnt}, 32'd7);
        chk("hp_stay_pc", {24'd0, pc}, 32'h03);

        // Reset mid-EXEC with a stray ack in the reset cycle.
        reset   = 1'b1;
        halt    = 1'b0;
        pc_load = 1'b0;
        tick();
        reset      = 1'b0;
        instr_done = 1'b0;
        mem_ack    = 1'b1;
        push(8'h00);
        tick();
        pop_chk("rx_i0");
        reset      = 1'b1;
        instr_done = 1'b1;
        tick();
        chk("rx_pc", {24'd0, pc}, 32'h00);
        chk("rx_valid", {31'd0, instr_valid}, 32'd0);
        chk("rx_cnt", {16'd0, retired_cnt}, 32'd0);
        chk("rx_op", {28'd0, opcode}, 32'h0);
        chk("rx_req_in_rst", {31'd0, mem_req}, 32'd0);
        reset   = 1'b0;
        mem_ack = 1'b0;
        #1;
        chk("rx_req", {31'd0, mem_req}, 32'd1);
        tick();
        chk("rx_done_ign", {16'd0, retired_cnt}, 32'd0);
        chk("rx_pc2", {24'd0, pc}, 32'h00);
        chk("rx_valid2", {31'd0, instr_valid}, 32'd0);

        // Illegal opcode 0x5A.
        mem[8'h00] = 8'h5A;
        mem_ack    = 1'b1;
        instr_done = 1'b1;
        tick();
        chk("ill_halted", {31'd0, halted}, 32'd1);
        chk("ill_flag", {31'd0, illegal_op}, 32'd1);
        chk("ill_valid", {31'd0, instr_valid}, 32'd0);
        chk("ill_cnt", {16'd0, retired_cnt}, 32'd0);
        chk("ill_pc", {24'd0, pc}, 32'h00);
        chk("ill_op", {28'd0, opcode}, 32'h5);
        tick();
        chk("ill_stay_valid", {31'd0, instr_valid}, 32'd0);
        chk("ill_stay_flag", {31'd0, illegal_op}, 32'd1);

        chk("sb_empty", sb.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Upstream fetch stage of the TRISC core: owns the program counter (PC) and the instruction register (IR).
- Fetches one instruction word per cycle-pair over a req/ack memory handshake.
- Presents the 4-bit opcode, as the one-hot opcode decoder's w,x,y,z inputs, and the operand to the execute stage.
- Holds them stable until the execute stage signals completion, then advances or loads the PC.
- Traps undefined opcodes and supports halt.

Parameters:
- ADDR_W, 8, PC / memory address width.
- INSTR_W, 8, instruction word width; opcode = IR[INSTR_W-1:INSTR_W-4], operand = IR[INSTR_W-5:0]; INSTR_W >= 5.
- CNT_W, 16, retired-instruction counter width.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- mem_req  out  1  fetch request; address valid while high.
- mem_addr  out  ADDR_W  fetch address (= PC).
- mem_ack  in  1  read data valid this cycle.
- mem_rdata  in  INSTR_W  instruction word.
- opcode  out  4  IR opcode field, to decoder {w,x,y,z}.
- operand  out  INSTR_W-4  IR operand field.
- instr_valid  out  1  opcode/operand valid for execute.
- instr_done  in  1  execute stage finished current instruction.
- pc_load  in  1  branch/jump taken; sampled with instr_done.
- pc_load_val  in  ADDR_W  branch target.
- halt  in  1  stop after current instruction; sampled with instr_done.
- pc  out  ADDR_W  current PC.
- halted  out  1  core stopped.
- illegal_op  out  1  sticky: undefined opcode fetched.
- retired_cnt  out  CNT_W  instructions completed.

Behaviour:
- Reset is synchronous; all state updates on rising clk.
- Reset values: state=FETCH, PC=0, IR=0, halted=0, illegal_op=0, retired_cnt=0, instr_valid=0.
- mem_req = (state==FETCH) && !reset.
- mem_addr = PC at all times.
- Reset mid-operation aborts any fetch or execute immediately; an ack arriving in the reset cycle is ignored.
- Legal opcodes: 0000, 0001, 0010, 0011, 0100, 0110, 0111, 1000, 1001, 1100, 1111.
- Illegal opcodes: 0101, 1010, 1011, 1101, 1110.
- FETCH:
  - mem_req=1, instr_valid=0. Stays in FETCH while mem_ack=0; no timeout.
  - On an edge with mem_ack=1, IR <= mem_rdata.
  - If the new opcode is legal: state <= EXEC.
  - If illegal: state <= HALTED, illegal_op <= 1; PC not advanced.
- EXEC:
  - mem_req=0, instr_valid=1. opcode/operand stable for the whole state.
  - Latency: ack in cycle N -> instr_valid=1 in cycle N+1.
  - Waits while instr_done=0.
  - On an edge with instr_done=1: retired_cnt += 1 (wraps at 2^CNT_W).
  - Then, if halt=1: state <= HALTED, PC unchanged (halt has priority over pc_load).
  - Else if pc_load=1: PC <= pc_load_val, state <= FETCH.
  - Else: PC <= PC+1, wrapping 2^ADDR_W-1 -> 0; state <= FETCH.
- HALTED:
  - mem_req=0, instr_valid=0, halted=1.
  - Exits only via reset.
  - All inputs ignored.
- Input sampling rules:
  - mem_ack outside FETCH is ignored; IR unchanged.
  - instr_done, pc_load, halt are ignored outside EXEC.
  - pc_load and halt are only sampled on the instr_done edge.
- Minimum instruction period: 2 cycles (ack immediately, done immediately).
- opcode/operand in FETCH/HALTED show the last IR value; consumers qualify with instr_valid.

Test Plan:
- Reset release, mem_ack tied high with word 0x10 at addr 0 and 0x23 at addr 1, instr_done high in EXEC -> mem_addr sequence 0,1,2; opcode 1 then 2; instr_valid alternates 0/1; retired_cnt=2 after 4 cycles.
- Delayed ack: mem_ack held low 5 cycles -> mem_req stays 1 and mem_addr stays constant; instr_valid rises exactly one cycle after the ack edge.
- Branch: in EXEC assert instr_done with pc_load=1, pc_load_val=0x40 -> next mem_addr=0x40. At PC=0xFF without pc_load -> next PC=0x00.
- Illegal opcode: mem_rdata=0x5A -> halted=1 and illegal_op=1 next cycle; instr_valid never rises; retired_cnt unchanged; PC unchanged.
- Halt priority: instr_done=1 with halt=1 and pc_load=1 (val 0x10) at PC=0x03 -> halted=1, PC stays 0x03, retired_cnt increments, mem_req stays 0.
- Reset mid-EXEC with instr_valid=1 -> next cycle PC=0, instr_valid=0, mem_req=1, counters and flags cleared; later instr_done and stray mem_ack ignored.
